// File: rtl/reg_bus_pkg.sv
// Shared types and constants for the register-bus initiator: command byte layout,
// FSM state encoding and the read-back value used for unpopulated module slots.
package reg_bus_pkg;

    localparam int IOC_W  = 5;
    localparam int DATA_W = 8;
    localparam int SEL_W  = 2;

    localparam int CMD_RW_BIT = 7;
    localparam int CMD_SEL_HI = 6;
    localparam int CMD_SEL_LO = 5;
    localparam int CMD_IOC_HI = 4;
    localparam int CMD_IOC_LO = 0;

    localparam logic [DATA_W-1:0] RD_INVALID = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        WR_STROBE,
        RD_FETCH,
        RD_WAIT,
        RD_RESP
    } bus_state_t;

    typedef struct packed {
        logic             rd;
        logic [SEL_W-1:0] sel;
        logic [IOC_W-1:0] ioc;
    } cmd_t;

    function automatic cmd_t decode_cmd(input logic [DATA_W-1:0] b);
        cmd_t c;
        c.rd  = b[CMD_RW_BIT];
        c.sel = b[CMD_SEL_HI:CMD_SEL_LO];
        c.ioc = b[CMD_IOC_HI:CMD_IOC_LO];
        return c;
    endfunction

    function automatic logic sel_in_range(input logic [SEL_W-1:0] sel, input int n);
        return (int'(sel) < n);
    endfunction

endpackage

// File: rtl/reg_bus_rd_mux.sv
// Registered read-data select: captures the addressed slave's byte, or RD_INVALID
// when the module select points past the populated slaves.
module reg_bus_rd_mux
    import reg_bus_pkg::*;
#(
    parameter int N_MODULES = 4
) (
    input  logic                          i_sys_clk,
    input  logic                          i_rst,
    input  logic                          capture,
    input  logic [SEL_W-1:0]              sel,
    input  logic [DATA_W*N_MODULES-1:0]   rd_data,
    output logic [DATA_W-1:0]             rd_byte
);

    logic [DATA_W-1:0] sel_byte;

    // Loop compare keeps every slice index constant, so an out-of-range select never slices.
    always_comb begin
        sel_byte = RD_INVALID;
        for (int k = 0; k < N_MODULES; k++) begin
            if (sel == SEL_W'(k)) begin
                sel_byte = rd_data[DATA_W*k +: DATA_W];
            end
        end
    end

    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_byte <= '0;
        end else if (capture) begin
            rd_byte <= sel_byte;
        end
    end

endmodule

// File: rtl/reg_bus_master.sv
// Register-bus initiator: parses SPI bytes into fetch/load strobes on up to four slaves.
// Optional REG_BUS_MASTER_AUTOINC_EN turns bytes after a write into a write burst at ioc+1.
module reg_bus_master
    import reg_bus_pkg::*;
#(
    parameter int N_MODULES = 4
) (
    input  logic                          i_sys_clk,
    input  logic                          i_rst,
    input  logic [7:0]                    i_rx_data,
    input  logic                          i_rx_valid,
    input  logic                          i_frame_active,
    output logic [7:0]                    o_tx_data,
    output logic                          o_tx_valid,
    output logic [4:0]                    o_ioc,
    output logic [7:0]                    o_data_out,
    output logic [N_MODULES-1:0]          o_cs,
    output logic                          o_fetch_cmd,
    output logic                          o_load_cmd,
    input  logic [8*N_MODULES-1:0]        i_rd_data,
    output logic                          o_err_sel,
    output logic                          o_err_overrun
);

    bus_state_t             state, state_n;
    cmd_t                   cmd_q, cmd_n;
    logic [DATA_W-1:0]      data_q, data_n;
    logic [N_MODULES-1:0]   cs_q, cs_n;
    logic                   fetch_q, fetch_n;
    logic                   load_q, load_n;
    logic                   tx_valid_q, tx_valid_n;
    logic                   err_sel_q, err_sel_n;
    logic                   overrun_q, overrun_n;
    logic                   rd_capture;
    logic                   strobe_n;
    logic                   sel_ok;

    always_comb begin
        state_n    = state;
        cmd_n      = cmd_q;
        data_n     = data_q;
        overrun_n  = 1'b0;
        rd_capture = 1'b0;

        // A dropped frame wins over everything, including a byte strobed on the same edge.
        if (!i_frame_active) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (i_rx_valid) begin
                        cmd_n   = decode_cmd(i_rx_data);
                        state_n = cmd_n.rd ? RD_FETCH : WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (i_rx_valid) begin
                        data_n  = i_rx_data;
                        state_n = WR_STROBE;
                    end
                end
                WR_STROBE: begin
                    overrun_n = i_rx_valid;
`ifdef REG_BUS_MASTER_AUTOINC_EN
                    cmd_n.ioc = cmd_q.ioc + 5'd1;
                    state_n   = WR_DATA;
`else
                    state_n   = IDLE;
`endif
                end
                RD_FETCH: begin
                    overrun_n = i_rx_valid;
                    state_n   = RD_WAIT;
                end
                RD_WAIT: begin
                    overrun_n  = i_rx_valid;
                    rd_capture = 1'b1;
                    state_n    = RD_RESP;
                end
                RD_RESP: begin
                    overrun_n = i_rx_valid;
                    state_n   = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end

        // Strobes are computed from the next state so they appear registered in that state.
        strobe_n   = (state_n == WR_STROBE) || (state_n == RD_FETCH);
        sel_ok     = sel_in_range(cmd_n.sel, N_MODULES);
        load_n     = (state_n == WR_STROBE) && sel_ok;
        fetch_n    = (state_n == RD_FETCH) && sel_ok;
        err_sel_n  = strobe_n && !sel_ok;
        tx_valid_n = (state_n == RD_RESP);
        cs_n       = '0;
        for (int k = 0; k < N_MODULES; k++) begin
            cs_n[k] = strobe_n && sel_ok && (cmd_n.sel == SEL_W'(k));
        end
    end

    always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= IDLE;
            cmd_q      <= '0;
            data_q     <= '0;
            cs_q       <= '0;
            fetch_q    <= 1'b0;
            load_q     <= 1'b0;
            tx_valid_q <= 1'b0;
            err_sel_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state      <= state_n;
            cmd_q      <= cmd_n;
            data_q     <= data_n;
            cs_q       <= cs_n;
            fetch_q    <= fetch_n;
            load_q     <= load_n;
            tx_valid_q <= tx_valid_n;
            err_sel_q  <= err_sel_n;
            overrun_q  <= overrun_n;
        end
    end

    reg_bus_rd_mux #(
        .N_MODULES (N_MODULES)
    ) u_rd_mux (
        .i_sys_clk (i_sys_clk),
        .i_rst     (i_rst),
        .capture   (rd_capture),
        .sel       (cmd_q.sel),
        .rd_data   (i_rd_data),
        .rd_byte   (o_tx_data)
    );

    assign o_tx_valid    = tx_valid_q;
    assign o_ioc         = cmd_q.ioc;
    assign o_data_out    = data_q;
    assign o_cs          = cs_q;
    assign o_fetch_cmd   = fetch_q;
    assign o_load_cmd    = load_q;
    assign o_err_sel     = err_sel_q;
    assign o_err_overrun = overrun_q;

endmodule

// File: doc/reg_bus_master.md
# reg_bus_master

Initiator side of the internal register bus: turns a byte stream from the SPI deserializer into single-cycle fetch/load transactions on per-module register slaves (sys_ctrl-class targets with ioc/cs/fetch/load ports), and returns read data as a response byte. It sits between the SPI front end and up to four control-register modules, on the system clock domain.

## Interface
Parameters:
- N_MODULES, 4, number of attached slaves. Legal range 1..4, because the module-select field is 2 bits.

Ports:
- i_sys_clk  in  1  system clock
- i_rst  in  1  asynchronous, active-high reset
- i_rx_data  in  8  byte received from SPI
- i_rx_valid  in  1  one-cycle strobe per received byte
- i_frame_active  in  1  high while the SPI frame (chip select) is active
- o_tx_data  out  8  read response byte
- o_tx_valid  out  1  one-cycle strobe, response ready
- o_ioc  out  5  register index to slaves
- o_data_out  out  8  write data to slaves (their i_data_in)
- o_cs  out  N_MODULES  one-hot slave select
- o_fetch_cmd  out  1  read strobe
- o_load_cmd  out  1  write strobe
- i_rd_data  in  8*N_MODULES  slave o_data_out buses, concatenated; slave k is at [8k+7:8k]
- o_err_sel  out  1  one-cycle pulse: module select is at or above N_MODULES
- o_err_overrun  out  1  one-cycle pulse: a byte arrived while busy and was dropped

## Operation
- Command byte fields:
  - bit7: 1 = read, 0 = write.
  - bits6:5: module select.
  - bits4:0: ioc.
- States: IDLE, WR_DATA, WR_STROBE, RD_FETCH, RD_WAIT, RD_RESP.
- IDLE: on i_rx_valid with i_frame_active high, latch cmd.
  - Read command: go to RD_FETCH.
  - Write command: go to WR_DATA.
- WR_DATA: on i_rx_valid, latch the byte into o_data_out and go to WR_STROBE.
- WR_STROBE: o_cs[sel], o_load_cmd and o_ioc valid for exactly one cycle; then IDLE.
- RD_FETCH: o_cs[sel], o_fetch_cmd and o_ioc valid for one cycle; then RD_WAIT.
- RD_WAIT: capture i_rd_data slice[sel]; then RD_RESP.
- RD_RESP: drive o_tx_data and pulse o_tx_valid; then IDLE.
- Strobe rules: o_fetch_cmd and o_load_cmd are never high together. o_cs is all-zero outside WR_STROBE and RD_FETCH.
- Invalid select (sel ≥ N_MODULES):
  - No cs or strobe is issued, and o_err_sel pulses.
  - A read still returns 8'hFF through RD_RESP.
  - A write still consumes its data byte.
- An i_rx_valid in RD_FETCH, RD_WAIT, RD_RESP or WR_STROBE drops the byte and pulses o_err_overrun.
- i_frame_active low in any state returns the FSM to IDLE on the next edge.
  - Pending strobes are cancelled; a partial write issues no load.
  - i_rx_valid with i_frame_active low is ignored.
- Bytes after a completed transaction in the same frame are parsed as new commands (unless the configuration macro is defined).

## Timing
- Reset value of every output: 0, including o_tx_data = 8'h00 and o_cs = 0. The FSM resets to IDLE.
- All outputs are registered.
- Read: cmd strobe at edge 0 → fetch high in cycle 1 → slave data sampled at end of cycle 2 → o_tx_valid high in cycle 3. Latency is 3 cycles.
- Write: data strobe at edge 0 → load high in cycle 1, with o_data_out and o_ioc already stable.
- Simultaneous i_rx_valid and frame drop: the drop wins and the byte is discarded.
- A reset asserted mid-transaction clears strobes asynchronously; no partial load reaches a slave.

## Configuration
- REG_BUS_MASTER_AUTOINC_EN defined: after a write completes in a frame, each further byte is write data for ioc+1.
  - The ioc wraps from 31 to 0; the module select is kept.
  - Burst ends only when i_frame_active falls.
  - Reads are unaffected.
- Undefined: every byte after a completed transaction is a new command byte.

## Structure
- Package reg_bus_pkg holds:
  - the state enum;
  - command bit positions (RW bit 7, SEL 6:5, IOC 4:0);
  - IOC_W = 5 and DATA_W = 8;
  - RD_INVALID = 8'hFF.
- One sub-module, reg_bus_rd_mux: a registered select of i_rd_data by sel, returning RD_INVALID when out of range.

## Test plan
- Write 0x05/0x07 (sys_ctrl debug_modes) on module 0 → one-cycle o_cs=0001, o_load_cmd=1, o_ioc=5, o_data_out=0x07 one cycle after the data strobe.
- Read 0x80 with i_rd_data[7:0]=0x01 → o_fetch_cmd for one cycle, then o_tx_data=0x01 with o_tx_valid exactly 3 cycles after the cmd strobe.
- Read 0xE0 with N_MODULES=2 → o_err_sel pulse, no cs, o_tx_data=0xFF.
- Write cmd 0x05, then i_frame_active drops before the data byte → FSM in IDLE, no o_load_cmd ever.
- Byte strobed during RD_WAIT → o_err_overrun pulse, read still completes with correct data.
- With REG_BUS_MASTER_AUTOINC_EN: 0x1F, 0xAA, 0xBB → loads to ioc 31 (0xAA) then ioc 0 (0xBB).
